// File: rtl/idct_pkg.sv
// idct_pkg: shared widths, FSM state codes, coefficient matrix and output saturation for the 4x4 inverse DCT
package idct_pkg;
   localparam int CW = 10;
   localparam int ZW = 13;
   localparam int OW = 8;
   localparam int PW = 23;
   localparam logic [1:0] IDLE = 2'd0, INPUT = 2'd1, CALC = 2'd2, OUTPUT = 2'd3;
   localparam logic signed [7:0] C [4][4] = '{
      '{8'sd64,  8'sd64,  8'sd64,  8'sd64},
      '{8'sd83,  8'sd34, -8'sd34, -8'sd83},
      '{8'sd64, -8'sd64, -8'sd64,  8'sd64},
      '{8'sd34, -8'sd83,  8'sd83, -8'sd34}
   };
   function automatic logic signed [OW-1:0] sat8(input logic signed [PW-1:0] v);
      return v > 23'sd127 ? 8'sh7f : v < -23'sd128 ? 8'sh80 : v[OW-1:0];
   endfunction
endpackage

// File: rtl/idct_if.sv
// idct_if: streaming bus of the inverse DCT
//   in_valid/in_data   : coefficient stream into the transform (10-bit signed)
//   out_valid/out_data : reconstructed sample stream out of the transform (8-bit signed)
interface idct_if;
   import idct_pkg::*;
   logic                 in_valid;
   logic signed [CW-1:0] in_data;
   logic                 out_valid;
   logic signed [OW-1:0] out_data;
   modport master (output in_valid, in_data, input out_valid, out_data);
   modport slave  (input in_valid, in_data, output out_valid, out_data);
endinterface

// File: rtl/idct_dot4.sv
// idct_dot4: combinational 4-term signed dot product scaled by 1/128, truncated toward zero
//   a_i   : four 13-bit signed operands
//   b_i   : four 8-bit signed coefficients
//   dot_o : 23-bit signed (sum a*b) / 128
module idct_dot4
   import idct_pkg::*;
(
   input  logic signed [ZW-1:0] a_i [4],
   input  logic signed [7:0]    b_i [4],
   output logic signed [PW-1:0] dot_o
);
   logic signed [20:0]   p [4];
   logic signed [PW-1:0] sum;
   always_comb begin
      sum = '0;
      for (int i = 0; i < 4; i++) begin
         p[i] = 21'(a_i[i]) * 21'(b_i[i]);
         sum  = sum + PW'(p[i]);
      end
      // signed division rounds toward zero, unlike an arithmetic shift
      dot_o = sum / 23'sd128;
   end
endmodule

// File: rtl/idct.sv
// idct: 4x4 inverse integer DCT, serial row-major in, serial saturated row-major out
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, aborts any block in flight
//   bus   : idct_if slave (in_valid/in_data in, out_valid/out_data out)
module idct
   import idct_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   idct_if.slave bus
);
   logic [1:0]           state_q, state_d;
   logic [3:0]           in_cnt_q, in_cnt_d;
   logic [4:0]           cnt_q, cnt_d;
   logic [3:0]           out_cnt_q, out_cnt_d;
   logic                 out_valid_q;
   logic signed [OW-1:0] out_data_q;
   logic signed [CW-1:0] y_q [4][4];
   logic signed [ZW-1:0] z_q [4][4];
   logic signed [OW-1:0] x_q [4][4];
   logic signed [ZW-1:0] a [4];
   logic signed [7:0]    b [4];
   logic signed [PW-1:0] dot;
   logic                 capture, calc, pass2;
   logic [3:0]           k;

   assign capture = bus.in_valid && (state_q == IDLE || state_q == INPUT);
   assign calc    = state_q == CALC;
   assign pass2   = cnt_q[4];
   assign k       = cnt_q[3:0];

   always_comb begin
      state_d   = (state_q == IDLE   &&  bus.in_valid)      ? INPUT  :
                  (state_q == INPUT  && !bus.in_valid)      ? CALC   :
                  (state_q == CALC   && cnt_q == 5'd31)     ? OUTPUT :
                  (state_q == OUTPUT && out_cnt_q == 4'd15) ? IDLE   : state_q;
      in_cnt_d  = capture ? in_cnt_q + 4'd1 : 4'd0;
      cnt_d     = calc ? cnt_q + 5'd1 : 5'd0;
      out_cnt_d = state_q == OUTPUT ? out_cnt_q + 4'd1 : 4'd0;
   end

   // pass 1: Z[r][c] = sum_j C[j][r]*Y[j][c]; pass 2: X[r][c] = sum_j Z[r][j]*C[j][c]
   always_comb begin
      for (int j = 0; j < 4; j++) begin
         a[j] = pass2 ? z_q[k[3:2]][j] : {{(ZW-CW){y_q[j][k[1:0]][CW-1]}}, y_q[j][k[1:0]]};
         b[j] = pass2 ? C[j][k[1:0]] : C[j][k[3:2]];
      end
   end

   idct_dot4 u_dot (.a_i(a), .b_i(b), .dot_o(dot));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         in_cnt_q    <= '0;
         cnt_q       <= '0;
         out_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
               y_q[r][c] <= '0;
               z_q[r][c] <= '0;
               x_q[r][c] <= '0;
            end
         end
      end else begin
         state_q     <= state_d;
         in_cnt_q    <= in_cnt_d;
         cnt_q       <= cnt_d;
         out_cnt_q   <= out_cnt_d;
         if (capture) y_q[in_cnt_q[3:2]][in_cnt_q[1:0]] <= bus.in_data;
         // |Z| stays within 13 bits, so the upper dot bits are redundant sign
         if (calc && !pass2) z_q[k[3:2]][k[1:0]] <= dot[ZW-1:0];
         if (calc && pass2) x_q[k[3:2]][k[1:0]] <= sat8(dot);
         out_valid_q <= state_q == OUTPUT;
         out_data_q  <= state_q == OUTPUT ? x_q[out_cnt_q[3:2]][out_cnt_q[1:0]] : '0;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_idct.sv
// tb_idct: randomized self-checking bench for idct against a matrix-level reference model
module tb_idct;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_cmp = 0;
   int n_bad = 0;
   int my [16];
   int mx [16];
   int blk [32];
   int cm [4][4] = '{'{64, 64, 64, 64}, '{83, 34, -34, -83}, '{64, -64, -64, 64}, '{34, -83, 83, -34}};

   idct_if bus ();
   idct dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // X = sat(((C^T * Y) / 128) * C / 128) with truncating integer division
   function automatic void model();
      int z [4][4];
      int s;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            s = 0;
            for (int j = 0; j < 4; j++) s += cm[j][r] * my[j*4+c];
            z[r][c] = s / 128;
         end
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            s = 0;
            for (int j = 0; j < 4; j++) s += z[r][j] * cm[j][c];
            s = s / 128;
            mx[r*4+c] = s > 127 ? 127 : s < -128 ? -128 : s;
         end
   endfunction

   task automatic clear_blk();
      for (int i = 0; i < 32; i++) blk[i] = 0;
   endtask

   task automatic rand_blk();
      for (int i = 0; i < 32; i++) blk[i] = int'($urandom_range(0, 1023)) - 512;
   endtask

   task automatic send(input int n);
      for (int i = 0; i < n; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 10'(blk[i]);
         my[i%16]     = blk[i];
         step();
      end
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      model();
   endtask

   task automatic collect(input string name, input bit busy);
      int lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 100) begin
         if (busy) begin
            bus.in_valid = lat >= 5 && lat < 10;
            bus.in_data  = 10'sd100;
         end
         step();
         lat++;
      end
      bus.in_valid = 1'b0;
      n_cmp++;
      if (lat != 35) begin
         n_bad++;
         $display("FAIL %s latency: got %0d cycles, want 35", name, lat);
      end
      if (lat >= 100) return;
      for (int i = 0; i < 16; i++) begin
         n_cmp++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(mx[i])) begin
            n_bad++;
            $display("FAIL %s out[%0d]: got valid=%b data=%0d, want valid=1 data=%0d",
                     name, i, bus.out_valid, bus.out_data, mx[i]);
         end
         if (busy) bus.in_valid = i >= 2 && i < 6;
         step();
      end
      bus.in_valid = 1'b0;
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 8'sd0) begin
         n_bad++;
         $display("FAIL %s tail: got valid=%b data=%0d, want valid=0 data=0",
                  name, bus.out_valid, bus.out_data);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 12; i++) begin
         bus.in_valid = i[0];
         bus.in_data  = 10'($urandom);
         step();
         n_cmp++;
         if (bus.out_valid !== 1'b0 || bus.out_data !== 8'sd0) begin
            n_bad++;
            $display("FAIL reset hold: got valid=%b data=%0d, want valid=0 data=0",
                     bus.out_valid, bus.out_data);
         end
      end
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      for (int i = 0; i < 16; i++) my[i] = 0;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_dc();
      clear_blk();
      blk[0] = 256;
      send(16);
      collect("dc", 1'b0);
   endtask

   task automatic test_truncation();
      clear_blk();
      blk[0] = -3;
      send(16);
      collect("trunc", 1'b0);
   endtask

   task automatic test_saturation();
      clear_blk();
      blk[0] = 511;
      blk[4] = 511;
      send(16);
      collect("sat", 1'b0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 4; n++) begin
         rand_blk();
         send(16);
         collect("random", 1'b0);
      end
   endtask

   task automatic test_short_frame();
      rand_blk();
      send(10);
      collect("short", 1'b0);
   endtask

   task automatic test_long_frame();
      rand_blk();
      send(18);
      collect("long", 1'b0);
   endtask

   task automatic test_busy();
      rand_blk();
      send(16);
      collect("busy", 1'b1);
   endtask

   task automatic test_back_to_back();
      clear_blk();
      send(16);
      collect("b2b", 1'b0);
   endtask

   task automatic test_abort();
      int w = 0;
      int bad = 0;
      rand_blk();
      send(16);
      while (bus.out_valid !== 1'b1 && w < 100) begin
         step();
         w++;
      end
      n_cmp++;
      if (w >= 100) begin
         n_bad++;
         $display("FAIL abort wait: got no out_valid within 100 cycles, want stream");
      end
      repeat (3) step();
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 8'sd0) begin
         n_bad++;
         $display("FAIL abort async: got valid=%b data=%0d, want valid=0 data=0",
                  bus.out_valid, bus.out_data);
      end
      for (int i = 0; i < 16; i++) my[i] = 0;
      repeat (3) step();
      rst_n = 1'b1;
      for (int i = 0; i < 60; i++) begin
         step();
         if (bus.out_valid !== 1'b0 || bus.out_data !== 8'sd0) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL abort resume: got %0d cycles with output, want 0", bad);
      end
      rand_blk();
      send(16);
      collect("post_abort", 1'b0);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      test_reset();
      test_dc();
      test_truncation();
      test_saturation();
      test_random();
      test_short_frame();
      test_long_frame();
      test_busy();
      test_back_to_back();
      test_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
